// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state type, operand type and drain-length helper for the systolic feeder
package systolic_pkg;
  localparam int OPERAND_W = 8;
  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} feeder_state_e;
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/systolic_feeder_skew_line.sv
// skew_line: DEPTH-stage operand delay line with synchronous flush and zero insertion on idle cycles
module skew_line #(
  parameter int DEPTH = 1,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DEPTH-1:0][DW-1:0] sr;
  // shift one stage per cycle; stage 0 takes the slice only on a handshake, else a zero bubble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else if (flush) sr <= '0;
    else begin
      sr[0] <= en ? d : '0;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A columns / B rows into the systolic array and sequences one matrix op
// Optional SYSTOLIC_FEEDER_PERF_EN adds perf_cycles, the CLEAR-to-DONE cycle count of the last op.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int DW_IN = 8,
  parameter int CNT_W = $clog2(2*ARRAY_SIZE)+1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [ARRAY_SIZE*DW_IN-1:0] s_a_col,
  input  logic [ARRAY_SIZE*DW_IN-1:0] s_b_row,
  output logic [ARRAY_SIZE*DW_IN-1:0] a_edge,
  output logic [ARRAY_SIZE*DW_IN-1:0] b_edge,
  output logic                        pe_clr_n,
  output logic                        busy,
  output logic                        done
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [15:0]                 perf_cycles
`endif
);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ARRAY_SIZE-1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(drain_cycles(ARRAY_SIZE)-1);
  feeder_state_e state, state_n;
  logic [CNT_W-1:0] beat_cnt, beat_n, drain_cnt, drain_n;
  logic hs, flush;
  assign s_ready = state == FEED;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign pe_clr_n = state != CLEAR;
  assign flush = state == CLEAR;
  assign hs = s_valid && s_ready;
  // state and beat/drain counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      beat_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_n;
      beat_cnt <= beat_n;
      drain_cnt <= drain_n;
    end
  // sequencing: one clear cycle, N accepted beats, fixed drain, one done cycle
  always_comb begin
    state_n = state;
    beat_n = beat_cnt;
    drain_n = drain_cnt;
    unique case (state)
      IDLE: state_n = start ? CLEAR : IDLE;
      CLEAR: state_n = FEED;
      FEED: if (hs) begin
        beat_n = beat_cnt == LAST_BEAT ? '0 : beat_cnt + CNT_W'(1);
        state_n = beat_cnt == LAST_BEAT ? DRAIN : FEED;
      end
      DRAIN: begin
        drain_n = drain_cnt == LAST_DRAIN ? '0 : drain_cnt + CNT_W'(1);
        state_n = drain_cnt == LAST_DRAIN ? DONE : DRAIN;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    skew_line #(.DEPTH(i+1), .DW(DW_IN)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .en(hs),
      .d(s_a_col[i*DW_IN +: DW_IN]), .q(a_edge[i*DW_IN +: DW_IN])
    );
    skew_line #(.DEPTH(i+1), .DW(DW_IN)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .en(hs),
      .d(s_b_row[i*DW_IN +: DW_IN]), .q(b_edge[i*DW_IN +: DW_IN])
    );
  end
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0] run, run_inc;
  assign run_inc = run == 16'hFFFF ? run : run + 16'd1;
  // count CLEAR..DRAIN cycles and latch the total on DONE entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= '0;
      perf_cycles <= '0;
    end else begin
      run <= (state == IDLE || state == DONE) ? '0 : run_inc;
      if (state == DRAIN && state_n == DONE) perf_cycles <= run_inc;
    end
`endif
endmodule
